load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Memory-stage load/store unit that drives the word-addressed data memory (dmem).
//   - Takes byte-addressed load/store requests from the execute stage.
//   - Converts them to word accesses: combinational read, write on posedge.
//   - Byte/half stores use read-modify-write. Loads are sign- or zero-extended.
//   - Misaligned, out-of-range and reserved-size requests are rejected; memory is not touched.
// PARAMETERS
//   DEPTH  32  number of 32-bit words in dmem; valid word index 0..DEPTH-1
// PORTS
//   clk              in   1   single clock; all state changes on posedge
//   rst_n            in   1   asynchronous, active-low reset
//   req_valid        in   1   request present
//   req_ready        out  1   unit can accept; high only in IDLE
//   req_we           in   1   1=store, 0=load
//   req_size         in   2   00=byte, 01=half, 10=word, 11=reserved (error)
//   req_unsigned     in   1   loads: 1=zero-extend, 0=sign-extend
//   req_addr         in   32  byte address
//   req_wdata        in   32  store data; low 8/16/32 bits used per size
//   resp_valid       out  1   one-cycle completion pulse; no backpressure
//   resp_err         out  1   qualifies resp_valid: request rejected
//   resp_rdata       out  32  load result; 0 for stores and errors
//   mem_we           out  1   dmem write enable
//   mem_addr         out  32  dmem word index = {2'b00, addr_q[31:2]}
//   mem_wdata        out  32  dmem write data
//   mem_rdata        in   32  dmem combinational read data for mem_addr
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE; all request/data registers = 0.
//     - req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
//     - mem_we=0, mem_addr=0, mem_wdata=0.
//     - Reset in ACCESS or MERGE aborts the operation. mem_we drops at once and no write occurs.
//   Accept: in IDLE on a posedge with req_valid=1. Latch we, size, unsigned, addr, wdata.
//     - Error check at acceptance: size=11; half with addr[0]=1; word with addr[1:0]!=0;
//       addr[31:2] >= DEPTH. Any error -> ERR, otherwise -> ACCESS.
//   States:
//     IDLE   - req_ready=1. mem_we=0.
//     ACCESS - mem_addr driven. Action by request type:
//              load: extend the selected lane of mem_rdata into rdata_q -> RESP
//              word store: mem_we=1, mem_wdata=wdata_q -> RESP
//              byte/half store: word_q<=mem_rdata -> MERGE
//     MERGE  - mem_we=1. mem_wdata = word_q with lane replaced by wdata_q[7:0]/[15:0] -> RESP
//     RESP   - resp_valid=1, resp_err=0, resp_rdata=rdata_q (0 for stores) -> IDLE
//     ERR    - resp_valid=1, resp_err=1, resp_rdata=0; no mem access -> IDLE
//   Lane selection (little-endian):
//     - byte lane = addr_q[1:0], bits [8*k+7:8*k].
//     - half lane = addr_q[1], bits [16*h+15:16*h].
//   Extension: byte/half sign-extend from bit 7/15 unless unsigned. Word loads pass through unchanged.
//   Latency from the accept edge N:
//     - resp_valid in the cycle after edge N+2 for loads and word stores.
//     - N+3 for byte/half stores; N+1 for errors.
//   Throughput: one request in flight. req_ready=0 outside IDLE. A held req_valid is accepted
//     on the edge after the RESP/ERR cycle.
//   mem_addr and mem_wdata hold their last values when mem_we=0. mem_we is never high outside ACCESS/MERGE.
// TESTING
//   Word store addr=0x8, data=0xDEADBEEF; then word load 0x8 -> dmem[2]=0xDEADBEEF,
//     resp_rdata=0xDEADBEEF, err=0, response 2 cycles after each accept.
//   Preload dmem[1]=0x11223344; byte store 0xAB at addr 0x6 -> dmem[1]=0x11AB3344.
//     Exactly one mem_we pulse (MERGE), response 3 cycles after accept.
//   dmem[3]=0x80F0017F: lb 0xC -> 0x0000007F; lb 0xD -> 0x00000001;
//     lbu 0xE -> 0x000000F0; lh 0xE -> 0xFFFF80F0; lhu 0xE -> 0x000080F0.
//   Half load 0x3, word store 0x2, size=11, and word load 0x80 (DEPTH=32):
//     each -> resp_err=1 one cycle after accept, mem_we never asserted, dmem unchanged.
//   Byte store to 0x10: pull rst_n low during MERGE -> mem_we falls immediately, dmem[4] unchanged,
//     req_ready=1 after release, no resp_valid.
//   req_valid held high with back-to-back requests -> req_ready low during ACCESS/MERGE/RESP.
//     Each request gets exactly one resp_valid pulse, in order.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: converts byte-addressed requests into word accesses
// on a combinational-read / posedge-write dmem, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    MERGE  = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q;

  logic        req_err_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_ext_c;
  logic [31:0] merge_c;

  // Reject reserved size, misaligned halves/words and words beyond the memory.
  always_comb begin
    req_err_c = 1'b0;
    if (req_size == SZ_RSVD)
      req_err_c = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])
      req_err_c = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      req_err_c = 1'b1;
    if (req_addr[31:2] >= 30'(DEPTH))
      req_err_c = 1'b1;
  end

  // Little-endian lane extraction with optional sign extension.
  always_comb begin
    byte_c     = mem_rdata[{lane_q, 3'b000} +: 8];
    half_c     = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_ext_c = mem_rdata;
    case (size_q)
      SZ_BYTE: load_ext_c = {{24{byte_c[7] & ~unsigned_q}}, byte_c};
      SZ_HALF: load_ext_c = {{16{half_c[15] & ~unsigned_q}}, half_c};
      default: load_ext_c = mem_rdata;
    endcase
  end

  // Replace the addressed lane of the current word with the store data.
  always_comb begin
    merge_c = mem_rdata;
    if (size_q == SZ_BYTE)
      merge_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_c[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Control FSM; response outputs are registered one cycle behind RESP/ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0000;
      rdata_q    <= 32'h0000_0000;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
            rdata_q    <= 32'h0000_0000;
            req_ready  <= 1'b0;
            if (req_err_c) begin
              state <= ERR;
            end else begin
              state    <= ACCESS;
              mem_addr <= {2'b00, req_addr[31:2]};
              // Word stores write straight away during ACCESS.
              if (req_we && req_size == SZ_WORD) begin
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_ext_c;
            state   <= RESP;
          end else if (size_q == SZ_WORD) begin
            state <= RESP;
          end else begin
            mem_we    <= 1'b1;
            mem_wdata <= merge_c;
            state     <= MERGE;
          end
        end
        MERGE: begin
          state <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= rdata_q;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural dmem plus an arithmetic reference model
// of memory contents, load results, error rules, latency and write counts.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] dmem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          we_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < DEPTH) ? dmem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_addr < DEPTH) dmem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    dmem[idx] <= val;
    ref_mem[idx] = val;
    #1;
  endtask

  // Reference: error rules, load result, store effect on ref_mem, latency and write count.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output bit err, output int lat, output int nwr);
    int unsigned idx, off, sh, w, v, mask;
    idx = addr / 4;
    off = addr % 4;
    err = (size == 3) || (size == 1 && (off % 2) != 0) || (size == 2 && off != 0) || (idx >= DEPTH);
    rd = 0; lat = 1; nwr = 0;
    if (err) return;
    w = ref_mem[idx];
    if (!we) begin
      lat = 2;
      if (size == 0) begin
        v = (w >> (8 * off)) & 255;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (size == 1) begin
        v = (w >> (16 * (off / 2))) & 65535;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
        v = w;
      end
      rd = v;
    end else begin
      nwr = 1;
      if (size == 2) begin
        lat = 2;
        ref_mem[idx] = wdata;
      end else begin
        lat = 3;
        sh = (size == 0) ? 8 * off : 16 * (off / 2);
        mask = ((size == 0) ? 255 : 65535) << sh;
        ref_mem[idx] = (w & ~mask) | ((wdata << sh) & mask);
      end
    end
  endtask

  // Issue one request, wait for its response and compare everything against the model.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat, exp_wr, lat, w0, wait_cnt;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin
      @(posedge clk); #1; wait_cnt++;
    end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    model(we, size, uns, addr, wdata, exp_rd, exp_err, exp_lat, exp_wr);
    @(posedge clk); #1;
    w0 = we_cnt;
    if (!hold) req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 8) begin
      check("ready_low_busy", 32'(req_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rd);
    check("write_count", 32'(we_cnt - w0), 32'(exp_wr));
    if (!exp_err) check("dmem_word", dmem[addr[6:2]], ref_mem[addr[6:2]]);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          idx;
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then word load.
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0);

    // Byte store with read-modify-write.
    preload(1, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00AB, 1'b0);
    check("rmw_result", dmem[1], 32'h11AB_3344);

    // Sub-word loads with both extensions.
    preload(3, 32'h80F0_017F);
    do_req(1'b0, 2'b00, 1'b0, 32'hC, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'hD, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'hE, 32'h0, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'hE, 32'h0, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'hF, 32'h0, 1'b0);

    // Rejected requests.
    do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'h2, 32'h1234_5678, 1'b0);
    do_req(1'b1, 2'b11, 1'b0, 32'h4, 32'h1234_5678, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h7C + 32'h4, 32'hFF, 1'b0);

    // Reset asserted during MERGE aborts the write.
    preload(4, 32'hCAFE_F00D);
    idx = we_cnt;
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("merge_we_high", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_we_low", 32'(mem_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_dmem4", dmem[4], 32'hCAFE_F00D);
    check("abort_no_write", 32'(we_cnt - idx), 32'd0);

    // Back-to-back with req_valid held high.
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 1'b1);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 32'h24, 32'h0BAD_F00D, 1'b1);
    do_req(1'b0, 2'b11, 1'b0, 32'h24, 32'h0, 1'b1);
    do_req(1'b0, 2'b00, 1'b1, 32'h25, 32'h0, 1'b1);
    req_valid = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      a = {$urandom_range(0, 39) * 4} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      d = $urandom;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, d,
             1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) check("final_dmem", dmem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
